switch_allocator: RTL and testbench

Switch control logic that sits directly upstream of the router's mux-based crossbar and drives its select lines. It arbitrates per-input output-port requests with one round-robin arbiter per output. It reserves a crossbar path from head-flit grant until the tail-flit handshake completes and presents routeSelect/outputBusy/PortReserved in the encoding the crossbar consumes. It also guarantees one-input-per-output and one-output-per-input, which the crossbar itself does not enforce.

---
 rtl/switch_allocator.sv | 211 +++++++++++++++++++++
 tb/tb_switch_allocator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output round-robin switch allocator driving crossbar select lines
//
// Purpose:
//   One IDLE/BUSY FSM and one round-robin pointer per output. In IDLE, an
//   output grants the first requesting, unreserved input at or after its
//   pointer. The path stays reserved until the granted input completes a tail
//   handshake. Guarantees at most one input per output and one output per input.
//
// Optional feature macro: SWALLOC_WATCHDOG_EN
//   When defined, each output has a stall counter. A reservation whose input
//   stops moving is force-released, and wd_error pulses for that release.
//
// Ports:
//   clk          - clock, all state on rising edge
//   rst          - synchronous active-high reset
//   req_valid    - per input: head flit wants a path
//   req_port     - per input: requested output index (REQUEST_WIDTH each)
//   valid_in     - per input: flit valid at crossbar input
//   ready_in     - per input: crossbar ready toward input
//   tail_in      - per input: current flit is a tail
//   routeSelect  - per output: input index driving it (REQUEST_WIDTH each)
//   outputBusy   - per output: reserved
//   PortReserved - per input: holds a path
//   grant_pulse  - per input: one-cycle pulse on new grant
//   wd_error     - watchdog release pulse (0 when feature compiled out)

module switch_allocator #(
  parameter int INPUTS          = 4,
  parameter int OUTPUTS         = 4,
  parameter int REQUEST_WIDTH   = 32,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUTS-1:0]                 req_valid,
  input  logic [INPUTS*REQUEST_WIDTH-1:0]   req_port,
  input  logic [INPUTS-1:0]                 valid_in,
  input  logic [INPUTS-1:0]                 ready_in,
  input  logic [INPUTS-1:0]                 tail_in,
  output logic [OUTPUTS*REQUEST_WIDTH-1:0]  routeSelect,
  output logic [OUTPUTS-1:0]                outputBusy,
  output logic [INPUTS-1:0]                 PortReserved,
  output logic [INPUTS-1:0]                 grant_pulse,
  output logic                              wd_error
);

  localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  // Elaboration-time parameter sanity checks.
  if (INPUTS < 1 || OUTPUTS < 1) begin : g_bad_size
    $error("switch_allocator: INPUTS and OUTPUTS must be at least 1");
  end
  if (WATCHDOG_CYCLES < 1) begin : g_bad_wd
    $error("switch_allocator: WATCHDOG_CYCLES must be at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q [OUTPUTS];
  state_t            state_d [OUTPUTS];
  logic [IW-1:0]     owner_q [OUTPUTS];
  logic [IW-1:0]     owner_d [OUTPUTS];
  logic [IW-1:0]     ptr_q   [OUTPUTS];
  logic [IW-1:0]     ptr_d   [OUTPUTS];
  logic [INPUTS-1:0] grant_q;
  logic [INPUTS-1:0] grant_d;
  logic [INPUTS-1:0] reserved;

  logic [REQUEST_WIDTH-1:0] port_of [INPUTS];

`ifdef SWALLOC_WATCHDOG_EN
  localparam int CW = $clog2(WATCHDOG_CYCLES + 1);

  logic [CW-1:0]      stall_q [OUTPUTS];
  logic [CW-1:0]      stall_d [OUTPUTS];
  logic [OUTPUTS-1:0] phase_q;
  logic [OUTPUTS-1:0] phase_d;
  logic               wd_q;
  logic               wd_d;
`endif

  for (genvar j = 0; j < INPUTS; j++) begin : g_in
    assign port_of[j] = req_port[j*REQUEST_WIDTH +: REQUEST_WIDTH];
  end

  // An input is reserved while any BUSY output names it as owner.
  always_comb begin
    reserved = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      if (state_q[i] == BUSY) begin
        reserved[owner_q[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    grant_d = '0;
`ifdef SWALLOC_WATCHDOG_EN
    wd_d    = 1'b0;
    phase_d = phase_q;
`endif
    for (int i = 0; i < OUTPUTS; i++) begin
      state_d[i] = state_q[i];
      owner_d[i] = owner_q[i];
      ptr_d[i]   = ptr_q[i];
`ifdef SWALLOC_WATCHDOG_EN
      stall_d[i] = stall_q[i];
`endif
      found = 1'b0;
      idx   = '0;
      case (state_q[i])
        IDLE: begin
          // Scan from the pointer with wraparound; first hit wins. Releases only
          // reach IDLE on the following cycle, which gives the mandatory gap.
          for (int k = 0; k < INPUTS; k++) begin
            idx = IW'((int'(ptr_q[i]) + k) % INPUTS);
            if (!found && req_valid[idx] && !reserved[idx] &&
                (port_of[idx] == REQUEST_WIDTH'(i))) begin
              found      = 1'b1;
              state_d[i] = BUSY;
              owner_d[i] = idx;
              ptr_d[i]   = IW'((int'(idx) + 1) % INPUTS);
              grant_d[idx] = 1'b1;
`ifdef SWALLOC_WATCHDOG_EN
              stall_d[i] = '0;
              phase_d[i] = 1'b0;
`endif
            end
          end
        end
        default: begin
          if (valid_in[owner_q[i]] && ready_in[owner_q[i]] && tail_in[owner_q[i]]) begin
            state_d[i] = IDLE;
          end
`ifdef SWALLOC_WATCHDOG_EN
          else if (valid_in[owner_q[i]] && ready_in[owner_q[i]]) begin
            stall_d[i] = '0;
            phase_d[i] = 1'b0;
          end else begin
            // Counter advances on every second stalled cycle.
            phase_d[i] = ~phase_q[i];
            if (phase_q[i]) begin
              if (int'(stall_q[i]) + 1 >= WATCHDOG_CYCLES) begin
                state_d[i] = IDLE;
                stall_d[i] = '0;
                phase_d[i] = 1'b0;
                wd_d       = 1'b1;
              end else begin
                stall_d[i] = stall_q[i] + CW'(1);
              end
            end
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUTPUTS; i++) begin
        state_q[i] <= IDLE;
        owner_q[i] <= '0;
        ptr_q[i]   <= '0;
`ifdef SWALLOC_WATCHDOG_EN
        stall_q[i] <= '0;
`endif
      end
      grant_q <= '0;
`ifdef SWALLOC_WATCHDOG_EN
      phase_q <= '0;
      wd_q    <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < OUTPUTS; i++) begin
        state_q[i] <= state_d[i];
        owner_q[i] <= owner_d[i];
        ptr_q[i]   <= ptr_d[i];
`ifdef SWALLOC_WATCHDOG_EN
        stall_q[i] <= stall_d[i];
`endif
      end
      grant_q <= grant_d;
`ifdef SWALLOC_WATCHDOG_EN
      phase_q <= phase_d;
      wd_q    <= wd_d;
`endif
    end
  end

  for (genvar g = 0; g < OUTPUTS; g++) begin : g_out
    assign routeSelect[g*REQUEST_WIDTH +: REQUEST_WIDTH] =
      (state_q[g] == BUSY) ? REQUEST_WIDTH'(owner_q[g]) : '0;
    assign outputBusy[g] = (state_q[g] == BUSY);
  end

  assign PortReserved = reserved;
  assign grant_pulse  = grant_q;

`ifdef SWALLOC_WATCHDOG_EN
  assign wd_error = wd_q;
`else
  assign wd_error = 1'b0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - scoreboard bench for switch_allocator
module tb_switch_allocator;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_port;
  logic [3:0]   valid_in;
  logic [3:0]   ready_in;
  logic [3:0]   tail_in;
  logic [127:0] routeSelect;
  logic [3:0]   outputBusy;
  logic [3:0]   PortReserved;
  logic [3:0]   grant_pulse;
  logic         wd_error;

  switch_allocator #(
    .INPUTS(4), .OUTPUTS(4), .REQUEST_WIDTH(32), .WATCHDOG_CYCLES(1024)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_port(req_port),
    .valid_in(valid_in), .ready_in(ready_in), .tail_in(tail_in),
    .routeSelect(routeSelect), .outputBusy(outputBusy),
    .PortReserved(PortReserved), .grant_pulse(grant_pulse), .wd_error(wd_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int inp; int outp; } gexp_t;
  typedef struct {
    int cyc; logic [3:0] busy; logic [3:0] resv; logic [3:0] gp; logic [127:0] rs;
  } sexp_t;

  gexp_t gq[$];
  sexp_t sq[$];
  int checks = 0;
  int errors = 0;

  gexp_t ge;
  sexp_t se;
  logic [31:0] got_sel;

  // Monitor: grants pop the grant queue; snapshots are compared on their cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int j = 0; j < 4; j++) begin
        if (grant_pulse[j] === 1'b1) begin
          checks++;
          if (gq.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected cyc=%0d input=%0d", cyc, j);
          end else begin
            ge = gq.pop_front();
            got_sel = routeSelect[ge.outp*32 +: 32];
            if (ge.cyc != cyc || ge.inp != j || got_sel != 32'(j) || outputBusy[ge.outp] !== 1'b1) begin
              errors++;
              $display("FAIL grant cyc=%0d input=%0d sel=%0d busy=%b expected cyc=%0d input=%0d out=%0d",
                       cyc, j, got_sel, outputBusy, ge.cyc, ge.inp, ge.outp);
            end
          end
        end
      end
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        ge = gq.pop_front();
        checks++;
        errors++;
        $display("FAIL grant_missing expected cyc=%0d input=%0d out=%0d got none", ge.cyc, ge.inp, ge.outp);
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        se = sq.pop_front();
        checks++;
        if (se.cyc != cyc || outputBusy !== se.busy || PortReserved !== se.resv ||
            grant_pulse !== se.gp || routeSelect !== se.rs || wd_error !== 1'b0) begin
          errors++;
          $display("FAIL snapshot cyc=%0d busy=%b resv=%b gp=%b rs=%h wd=%b expected busy=%b resv=%b gp=%b rs=%h",
                   cyc, outputBusy, PortReserved, grant_pulse, routeSelect, wd_error,
                   se.busy, se.resv, se.gp, se.rs);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input int c, input int j, input int o);
    gexp_t e;
    e.cyc = c; e.inp = j; e.outp = o;
    gq.push_back(e);
  endtask

  task automatic exp_snap(input int c, input logic [3:0] b, input logic [3:0] r,
                          input logic [3:0] g, input int o0, input int o1,
                          input int o2, input int o3);
    sexp_t s;
    int own [4];
    own[0] = o0; own[1] = o1; own[2] = o2; own[3] = o3;
    s.cyc = c; s.busy = b; s.resv = r; s.gp = g; s.rs = '0;
    for (int k = 0; k < 4; k++) s.rs[k*32 +: 32] = b[k] ? 32'(own[k]) : 32'd0;
    sq.push_back(s);
  endtask

  task automatic set_port(input int j, input int p);
    req_port[j*32 +: 32] = 32'(p);
  endtask

  task automatic set_hs(input logic [3:0] v);
    valid_in = v; ready_in = v; tail_in = v;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    logic [5:0] pat;
    // Reset held 3 cycles with every input requesting its own index.
    rst = 1'b1; req_valid = 4'b1111; req_port = '0;
    for (int j = 0; j < 4; j++) set_port(j, j);
    set_hs(4'b0000);
    for (int c = 1; c <= 3; c++) exp_snap(c, 4'b0, 4'b0, 4'b0, 0, 0, 0, 0);
    tick; tick; tick;
    n = cyc;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) exp_grant(n + 1, j, j);
    exp_snap(n + 1, 4'b1111, 4'b1111, 4'b1111, 0, 1, 2, 3);
    exp_snap(n + 2, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tick;
    req_valid = 4'b0000; set_hs(4'b1111);
    tick;
    set_hs(4'b0000);

    // Single request in2 -> out1; a second request while reserved is ignored.
    n = cyc;
    req_valid = 4'b0100; set_port(2, 1);
    exp_grant(n + 1, 2, 1);
    exp_snap(n + 1, 4'b0010, 4'b0100, 4'b0100, 0, 2, 0, 0);
    exp_snap(n + 2, 4'b0010, 4'b0100, 4'b0000, 0, 2, 0, 0);
    exp_snap(n + 3, 4'b0010, 4'b0100, 4'b0000, 0, 2, 0, 0);
    exp_snap(n + 4, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tick;
    set_port(2, 3);
    tick; tick;
    req_valid = 4'b0000; set_hs(4'b0100);
    tick;
    set_hs(4'b0000);

    // Round-robin on out3 among inputs 0,1,3 with single-flit packets.
    n = cyc;
    set_port(0, 3); set_port(1, 3); set_port(3, 3);
    req_valid = 4'b1011; set_hs(4'b1011);
    exp_grant(n + 1, 0, 3);
    exp_grant(n + 3, 1, 3);
    exp_grant(n + 5, 3, 3);
    exp_grant(n + 7, 0, 3);
    exp_snap(n + 1, 4'b1000, 4'b0001, 4'b0001, 0, 0, 0, 0);
    exp_snap(n + 2, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    exp_snap(n + 3, 4'b1000, 4'b0010, 4'b0010, 0, 0, 0, 1);
    exp_snap(n + 8, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) tick;
    req_valid = 4'b0000;
    tick;
    set_hs(4'b0000);

    // Multi-flit hold on out0 by in1 with in3 competing.
    n = cyc;
    set_port(1, 0); set_port(3, 0);
    req_valid = 4'b1010;
    exp_grant(n + 1, 1, 0);
    exp_snap(n + 2, 4'b0001, 4'b0010, 4'b0000, 1, 0, 0, 0);
    exp_snap(n + 5, 4'b0001, 4'b0010, 4'b0000, 1, 0, 0, 0);
    exp_snap(n + 6, 4'b0001, 4'b0010, 4'b0000, 1, 0, 0, 0);
    exp_snap(n + 7, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    exp_grant(n + 8, 3, 0);
    exp_snap(n + 8, 4'b0001, 4'b1000, 4'b1000, 3, 0, 0, 0);
    exp_snap(n + 9, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tick;
    req_valid = 4'b1000;
    pat = 6'b101101;
    for (int k = 0; k < 6; k++) begin
      valid_in = 4'b0010;
      ready_in = pat[k] ? 4'b0010 : 4'b0000;
      tail_in  = (k >= 4) ? 4'b0010 : 4'b0000;
      tick;
    end
    set_hs(4'b0000);
    tick;
    req_valid = 4'b0000; set_hs(4'b1000);
    tick;
    set_hs(4'b0000);

    // Parallel grants plus out-of-range requests (7 and exactly OUTPUTS).
    n = cyc;
    set_port(0, 2); set_port(1, 0); set_port(2, 7); set_port(3, 4);
    req_valid = 4'b1111;
    exp_grant(n + 1, 0, 2);
    exp_grant(n + 1, 1, 0);
    exp_snap(n + 1, 4'b0101, 4'b0011, 4'b0011, 1, 0, 0, 0);
    exp_snap(n + 3, 4'b0101, 4'b0011, 4'b0000, 1, 0, 0, 0);
    exp_snap(n + 4, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    exp_snap(n + 6, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tick;
    req_valid = 4'b1100;
    tick; tick;
    set_hs(4'b0011);
    tick;
    set_hs(4'b0000);
    tick; tick;
    req_valid = 4'b0000;
    tick;

    // Reset mid-packet drops the path and returns pointers to 0.
    n = cyc;
    set_port(0, 1);
    req_valid = 4'b0001;
    exp_grant(n + 1, 0, 1);
    exp_snap(n + 2, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tick;
    rst = 1'b1; req_valid = 4'b0000;
    tick;
    rst = 1'b0;
    n = cyc;
    set_port(0, 2); set_port(3, 2);
    req_valid = 4'b1001;
    exp_grant(n + 1, 0, 2);
    exp_snap(n + 2, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    exp_grant(n + 3, 3, 2);
    exp_snap(n + 4, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tick;
    req_valid = 4'b1000; set_hs(4'b0001);
    tick;
    set_hs(4'b0000);
    tick;
    req_valid = 4'b0000; set_hs(4'b1000);
    tick;
    set_hs(4'b0000);
    tick; tick; tick;

    while (gq.size() > 0) begin
      ge = gq.pop_front();
      checks++; errors++;
      $display("FAIL grant_leftover expected cyc=%0d input=%0d out=%0d got none", ge.cyc, ge.inp, ge.outp);
    end
    while (sq.size() > 0) begin
      se = sq.pop_front();
      checks++; errors++;
      $display("FAIL snapshot_leftover expected cyc=%0d got none", se.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
